// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, ping-pong direction
// and the LED value each mode starts from.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'b00,
    MODE_RING  = 2'b01,
    MODE_PONG  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [3:0] SEED_BIN   = 4'b0000;
  localparam logic [3:0] SEED_RING  = 4'b0001;
  localparam logic [3:0] SEED_PONG  = 4'b0001;
  localparam logic [3:0] SEED_BLINK = 4'b1111;

  function automatic logic [3:0] seed_for(input mode_t m);
    logic [3:0] seed;
    case (m)
      MODE_BIN:   seed = SEED_BIN;
      MODE_RING:  seed = SEED_RING;
      MODE_PONG:  seed = SEED_PONG;
      MODE_BLINK: seed = SEED_BLINK;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Board-facing signals of the LED sequencer: prescaler tick, controls and LEDs.
interface led_sequencer_if;

  logic       TICK_IN;
  logic       RUN;
  logic [1:0] MODE;
  logic [3:0] LED;
  logic       STEP;

  modport master (
    output TICK_IN,
    output RUN,
    output MODE,
    input  LED,
    input  STEP
  );

  modport slave (
    input  TICK_IN,
    input  RUN,
    input  MODE,
    output LED,
    output STEP
  );

endinterface

// File: rtl/led_sequencer_tick_sync.sv
// Synchronizer plus rising-edge detector for a slow asynchronous square wave;
// emits a one-cycle pulse per genuine low-to-high transition.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] stages;
  logic [SYNC_STAGES-1:0] filled;
  logic                   prev;
  logic                   armed;

  // filled tracks which stages hold real samples; armed waits for a real low so
  // an input already high at reset release is not taken as a rise.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      stages <= '0;
      filled <= '0;
      prev   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
      filled <= {filled[SYNC_STAGES-2:0], 1'b1};
      prev   <= stages[SYNC_STAGES-1];
      if (filled[SYNC_STAGES-1] && !stages[SYNC_STAGES-1]) begin
        armed <= 1'b1;
      end
    end
  end

  // Requiring the last two stages high rejects single-cycle glitches.
  assign pulse = armed & stages[SYNC_STAGES-1] & stages[SYNC_STAGES-2] & ~prev;

endmodule

// File: rtl/led_sequencer.sv
// Turns every DIV synchronized prescaler rises into one step of a
// mode-selectable 4-LED pattern.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV         = 1
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  led_sequencer_if.slave   io
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

  logic          tick_edge;
  logic          step_fire;
  logic [DW-1:0] div_cnt;
  mode_t         req_mode;
  mode_t         cur_mode;
  dir_t          dir;
  logic [3:0]    led;
  logic          step;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .CLK_IN   (CLK_IN),
    .RST_N    (RST_N),
    .async_in (io.TICK_IN),
    .pulse    (tick_edge)
  );

  assign req_mode  = mode_t'(io.MODE);
  assign step_fire = io.RUN && tick_edge && (div_cnt == DIV_LAST);

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
    end else if (!io.RUN) begin
      div_cnt <= '0;
    end else if (tick_edge) begin
      div_cnt <= step_fire ? '0 : div_cnt + 1'b1;
    end
  end

  // A step in a newly requested mode only loads its seed; advancing starts
  // from the following step.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      led      <= 4'b0000;
      step     <= 1'b0;
      cur_mode <= MODE_BIN;
      dir      <= DIR_LEFT;
    end else begin
      step <= step_fire;
      if (step_fire) begin
        if (req_mode != cur_mode) begin
          cur_mode <= req_mode;
          led      <= seed_for(req_mode);
          dir      <= DIR_LEFT;
        end else begin
          case (cur_mode)
            MODE_BIN:   led <= led + 4'd1;
            MODE_RING:  led <= {led[2:0], led[3]};
            MODE_PONG: begin
              if (dir == DIR_LEFT) begin
                led <= {led[2:0], 1'b0};
                if (led == 4'b0100) dir <= DIR_RIGHT;
              end else begin
                led <= {1'b0, led[3:1]};
                if (led == 4'b0010) dir <= DIR_LEFT;
              end
            end
            MODE_BLINK: led <= ~led;
          endcase
        end
      end
    end
  end

  assign io.LED  = led;
  assign io.STEP = step;

endmodule

// File: tb/tb_led_sequencer.sv
// Drives two sequencers (DIV=1 and DIV=3) with one stimulus and checks both
// every cycle against a pattern-table model, plus hand-computed LED values.
module tb_led_sequencer;

  localparam int SYNC  = 2;
  localparam int DIV_A = 1;
  localparam int DIV_B = 3;

  localparam logic [3:0] PONG_SEQ [6] = '{4'b0001, 4'b0010, 4'b0100,
                                          4'b1000, 4'b0100, 4'b0010};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       run;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int due_q [$];

  logic [3:0] m_led  [2];
  logic       m_step [2];
  int         m_mode [2];
  int         m_pos  [2];
  int         m_cnt  [2];

  always #5 clk = ~clk;

  led_sequencer_if bus_a ();
  led_sequencer_if bus_b ();

  assign bus_a.TICK_IN = tick;
  assign bus_a.RUN     = run;
  assign bus_a.MODE    = mode;
  assign bus_b.TICK_IN = tick;
  assign bus_b.RUN     = run;
  assign bus_b.MODE    = mode;

  led_sequencer #(.SYNC_STAGES(SYNC), .DIV(DIV_A)) dut_a (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .io     (bus_a.slave)
  );

  led_sequencer #(.SYNC_STAGES(SYNC), .DIV(DIV_B)) dut_b (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .io     (bus_b.slave)
  );

  function automatic logic [3:0] seed_of(input int m);
    case (m)
      1:       return 4'b0001;
      2:       return 4'b0001;
      3:       return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_led[d]  = 4'b0000;
      m_step[d] = 1'b0;
      m_mode[d] = 0;
      m_pos[d]  = 0;
      m_cnt[d]  = 0;
    end
  endtask

  task automatic model_cycle(input int d, input int div, input bit edge_seen);
    bit fire;
    fire = 1'b0;
    if (run !== 1'b1) begin
      m_cnt[d] = 0;
    end else if (edge_seen) begin
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == div) begin
        m_cnt[d] = 0;
        fire = 1'b1;
      end
    end
    m_step[d] = fire;
    if (fire) begin
      if (int'(mode) != m_mode[d]) begin
        m_mode[d] = int'(mode);
        m_led[d]  = seed_of(int'(mode));
        m_pos[d]  = 0;
      end else begin
        case (m_mode[d])
          0: m_led[d] = 4'((int'(m_led[d]) + 1) % 16);
          1: m_led[d] = 4'(((int'(m_led[d]) * 2) % 16) + (int'(m_led[d]) / 8));
          2: begin
            m_pos[d] = (m_pos[d] + 1) % 6;
            m_led[d] = PONG_SEQ[m_pos[d]];
          end
          default: m_led[d] = 4'(15 - int'(m_led[d]));
        endcase
      end
    end
  endtask

  // Each genuine rise is recorded with the cycle its LED update must land on.
  always @(posedge clk or negedge rst_n) begin
    bit hit;
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc = cyc + 1;
      hit = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        hit = 1'b1;
        void'(due_q.pop_front());
      end
      model_cycle(0, DIV_A, hit);
      model_cycle(1, DIV_B, hit);
    end
  end

  task automatic check_output(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("led_a",  bus_a.LED, m_led[0]);
    check_output("step_a", {3'b000, bus_a.STEP}, {3'b000, m_step[0]});
    check_output("led_b",  bus_b.LED, m_led[1]);
    check_output("step_b", {3'b000, bus_b.STEP}, {3'b000, m_step[1]});
  end

  task automatic apply_stimulus(input logic r, input logic [1:0] m);
    @(posedge clk);
    #2;
    run  = r;
    mode = m;
  endtask

  task automatic tick_rise(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      tick = 1'b1;
      due_q.push_back(cyc + SYNC + 1);
      repeat (4) @(posedge clk);
      #2;
      tick = 1'b0;
      repeat (4) @(posedge clk);
    end
    #3;
  endtask

  task automatic pin_leds(input string tag, input logic [3:0] exp_a, input logic [3:0] exp_b);
    check_output({tag, "_a"}, bus_a.LED, exp_a);
    check_output({tag, "_b"}, bus_b.LED, exp_b);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b1;
    tick  = 1'b0;
    run   = 1'b0;
    mode  = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    pin_leds("reset_led", 4'b0000, 4'b0000);
    check_output("reset_step_a", {3'b000, bus_a.STEP}, 4'b0000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] binary count");
    apply_stimulus(1'b1, 2'b00);
    tick_rise(17);
    pin_leds("binary", 4'b0001, 4'b0101);

    $display("[TB] ping-pong");
    apply_stimulus(1'b1, 2'b10);
    tick_rise(8);
    pin_leds("pong", 4'b0010, 4'b0100);

    $display("[TB] divider and run");
    apply_stimulus(1'b0, 2'b10);
    repeat (2) @(posedge clk);
    apply_stimulus(1'b1, 2'b01);
    tick_rise(6);
    pin_leds("ring_div", 4'b0010, 4'b0010);
    apply_stimulus(1'b0, 2'b01);
    tick_rise(4);
    pin_leds("run_hold", 4'b0010, 4'b0010);
    apply_stimulus(1'b1, 2'b01);
    tick_rise(3);
    pin_leds("run_resume", 4'b0001, 4'b0100);

    $display("[TB] mode change");
    apply_stimulus(1'b1, 2'b11);
    tick_rise(3);
    pin_leds("blink_load", 4'b1111, 4'b1111);
    tick_rise(3);
    pin_leds("blink_off", 4'b0000, 4'b0000);
    tick_rise(3);
    pin_leds("blink_on", 4'b1111, 4'b1111);

    $display("[TB] glitch");
    @(posedge clk);
    #2 tick = 1'b1;
    @(posedge clk);
    #2 tick = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    pin_leds("glitch", 4'b1111, 4'b1111);

    $display("[TB] reset mid-operation");
    apply_stimulus(1'b1, 2'b01);
    tick_rise(4);
    check_output("pre_reset_a", bus_a.LED, 4'b1000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    due_q.delete();
    #1;
    pin_leds("async_reset", 4'b0000, 4'b0000);
    check_output("async_step_a", {3'b000, bus_a.STEP}, 4'b0000);
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #3;
    pin_leds("held_high", 4'b0000, 4'b0000);
    tick = 1'b0;
    repeat (5) @(posedge clk);
    tick_rise(1);
    pin_leds("post_reset", 4'b0001, 4'b0000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Downstream consumer of the multi-prescaler outputs. Takes one slow square wave from a prescaler pin (TICK_IN), re-times it into CLK_IN, and turns every DIV rising edges into one step of a 4-LED pattern state machine. Pattern is selected by MODE, and the output drives the board LEDs directly. Lets the team chain prescaler outputs into visible, mode-selectable light patterns without reworking the prescaler.

## Interface

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the TICK_IN synchronizer (≥2)
- DIV, 1, detected TICK_IN rising edges per pattern step (≥1)

Ports:
- CLK_IN  input  1  system clock; one clock domain only
- RST_N  input  1  reset; asynchronous, active-low
- TICK_IN  input  1  slow square wave from a prescaler pin; treated as asynchronous
- RUN  input  1  1 = advance on steps; 0 = hold pattern
- MODE  input  2  00 binary count, 01 ring rotate, 10 ping-pong, 11 blink
- LED  output  4  current pattern
- STEP  output  1  one-cycle pulse marking a pattern update

## Operation

- TICK_IN passes through SYNC_STAGES flops, then a rising-edge detector that produces a one-cycle `edge`.
- Divider counter, width $clog2(DIV) (min 1), counts edges while RUN=1.
  - A step fires when `edge` arrives with the counter at DIV-1; the counter then wraps to 0.
  - With RUN=0 the counter clears to 0 and edges are ignored.
- Registered mode (`cur_mode`) is compared with MODE on each step:
  - MODE ≠ cur_mode: load the seed for MODE and set cur_mode = MODE. No advance.
  - Otherwise: advance the pattern.
- Seeds: binary 0000, ring 0001, ping-pong 0001 with dir = LEFT, blink 1111.
- Advance rules:
  - binary: LED+1 mod 16 (1111→0000).
  - ring: rotate left (1000→0001).
  - ping-pong: two-state FSM, LEFT/RIGHT.
    - LEFT: shift left; on reaching 1000, go RIGHT.
    - RIGHT: shift right; on reaching 0001, go LEFT.
    - Sequence 0001,0010,0100,1000,0100,0010,0001…, period 6 steps, no repeated end values.
  - blink: LED = ~LED.
- MODE changes between steps have no effect until the next step.
- RUN changes take effect in the cycle they are sampled.

## Timing

- Reset values: LED=0000, STEP=0, cur_mode=00, dir=LEFT, divider=0, all synchronizer and edge flops 0.
- Latency: with RUN=1 and DIV=1, LED updates on the (SYNC_STAGES+1)th CLK_IN rising edge after TICK_IN rises.
- STEP is registered. It is high for exactly the one cycle following the LED update edge.
- TICK_IN must stay high and low for ≥ SYNC_STAGES+1 CLK_IN cycles each. Shorter pulses may be missed; this is not an error.
- A step at the same moment as a RUN falling edge: RUN=0 wins, with no update and no STEP.
- A step at the same moment as a MODE change: the seed loads, the pattern does not advance, and STEP still pulses.
- Reset asserted mid-pattern: all state returns to reset values immediately (asynchronous). After release, the first step in MODE≠00 loads a seed. In MODE=00, the first step gives 0001.
- TICK_IN held high through reset release produces no edge until it falls and rises again, because the synchronizer clears to 0 and the first rise is detected only after a genuine low.

## Structure

- Package `led_seq_pkg`:
  - mode encodings MODE_BIN, MODE_RING, MODE_PONG, MODE_BLINK
  - seed constants per mode
  - dir encoding DIR_LEFT/DIR_RIGHT
- Sub-module `tick_sync`: parameterised SYNC_STAGES synchronizer plus rising-edge detector. Ports CLK_IN, RST_N, async input, one-cycle pulse output. It is reusable for the other prescaler pins.
- Top holds the divider, cur_mode, dir, LED and STEP registers.

## Test plan

- Reset then binary count: reset, MODE=00, RUN=1, DIV=1, 17 TICK_IN rises → LED goes 0001…1111,0000,0001; exactly one STEP per rise, each at SYNC_STAGES+1 edges after the rise.
- Ping-pong: MODE=10, 8 rises → first rise loads 0001, then 0010,0100,1000,0100,0010,0001,0010; dir flips only at the ends.
- Divider and RUN: DIV=3, MODE=01, 6 rises → two steps (0001 seed, then 0010). Then RUN=0 for 4 rises → LED held at 0010, no STEP, divider cleared. RUN=1 plus 3 rises → 0100.
- Mode change: in ring at 0100, switch MODE=11 between steps → next step loads 1111 with STEP=1; following steps 0000, 1111.
- Glitch rejection: a 1-cycle TICK_IN high pulse → no edge, LED unchanged.
- Reset mid-operation: RST_N low asynchronously between clock edges while LED=1000 → LED=0000 and STEP=0 immediately. After release with TICK_IN held high, there is no step until TICK_IN falls and rises again.
